gppcu_rr_arbiter: RTL
=====================

Name: gppcu_rr_arbiter

Overview:
- Round-robin arbiter sharing one GPPCU resource among 2^EBW requesters; examples of the resource are the instruction/memory port and the broadcast bus.
- Each search step uses a lowest-set-bit priority search over the request vector, rotated so the search starts just after the last granted index. This guarantees fairness.
- A grant is held until the owner releases it, the owner drops its request, or a hold timeout expires.
- The block sits between the lane/requester logic and the shared resource's select mux.

Parameters:
- EBW, 4, index width; the requester count is N = 2^EBW.
- MAX_HOLD, 255, maximum cycles a grant may be held before forced release; must be ≥1.
- HBW, 8, hold-counter width; MAX_HOLD must be < 2^HBW.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  N  per-requester request level; must be held until granted or abandoned.
- DONE  in  1  release strobe from the current owner; only acted on while GNT_VALID=1.
- GNT  out  N  one-hot grant, registered; all zeros when no grant.
- GNT_IDX  out  EBW  binary index of the owner, registered; holds its last value when GNT_VALID=0.
- GNT_VALID  out  1  a grant is active.
- TIMEOUT  out  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset values, applied at any edge with RST=1 and overriding everything, including mid-grant:
  - GNT=0, GNT_IDX=0, GNT_VALID=0, TIMEOUT=0.
  - Hold counter = 0, state = IDLE.
  - Last-grant pointer LAST = N-1, so the first search starts at index 0.
- States: IDLE and BUSY. Only these two; encoding is free.
- IDLE:
  - If REQ≠0 at an edge, select W = the first set bit in the order LAST+1, LAST+2, …, LAST+N, all modulo N (wrap-around).
  - Register GNT = one-hot(W), GNT_IDX = W, GNT_VALID = 1, LAST = W, hold counter = 0, state → BUSY.
  - Grant latency is one cycle: REQ seen at edge k gives GNT visible after edge k.
  - If REQ=0, stay in IDLE and outputs are unchanged.
- BUSY: the following are evaluated each edge, in priority order.
  1. DONE=1 → release.
  2. REQ[GNT_IDX]=0 (owner abandons) → release.
  3. Hold counter = MAX_HOLD-1 → release with TIMEOUT=1 for exactly the next cycle.
  4. Otherwise, increment the hold counter; the grant is held.
- Release clears GNT and GNT_VALID, keeps GNT_IDX and LAST, and sets state → IDLE. There is no re-grant on the release edge; a one-cycle bubble always follows.
- Simultaneous DONE and timeout: DONE wins and TIMEOUT stays 0.
- A timed-out owner that keeps REQ asserted is eligible again, but only after every other active requester because LAST = its index.
- TIMEOUT is 0 in every cycle not immediately following a forced release.
- Requests arriving or changing while BUSY never alter GNT. Only REQ[GNT_IDX] is sampled.
- GNT is always one-hot or zero; GNT_IDX always equals the index of the set bit while GNT_VALID=1.
- N=2 (EBW=1) must work; a single requester alternates grant and bubble.
- Throughput: with continuous requests, each grant lasts ≥1 cycle plus a 1 bubble cycle.

Test Plan:
1. Reset, then REQ=16'h0000 for 5 cycles → GNT=0, GNT_VALID=0, GNT_IDX=0, TIMEOUT=0 throughout.
2. After reset, REQ=16'h8011 held and DONE pulsed one cycle after each grant → grant order 0, 4, 15, 0, 4, …; each GNT is one-hot and GNT_IDX matches it; one-cycle bubble between grants.
3. Grant to index 3, then hold REQ[3]=1 with DONE=0 and MAX_HOLD=4 → GNT_VALID high exactly 4 cycles, TIMEOUT=1 for 1 cycle after release, and index 3 is not re-granted while REQ[5]=1 (5 is granted next).
4. Owner 7 granted, REQ[7] dropped mid-grant → release on that edge with TIMEOUT=0; next grant goes to the next set bit after 7, wrapping (REQ=16'h0041 → index 0).
5. DONE and timeout on the same edge (MAX_HOLD=2, DONE on the 2nd grant cycle) → release with TIMEOUT=0.
6. RST asserted while BUSY with index 9 → all outputs zero after the edge; the next request 16'h0200|16'h0001 grants index 0 because the pointer was reset.

Source files
------------

// File: rtl/gppcu_rr_arbiter.sv
// Round-robin arbiter granting one shared GPPCU resource to one of 2^EBW requesters.
// A grant is held until DONE, until the owner drops REQ, or until MAX_HOLD cycles have elapsed.
module gppcu_rr_arbiter #(
    parameter int EBW      = 4,
    parameter int MAX_HOLD = 255,
    parameter int HBW      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [(1<<EBW)-1:0]   REQ,
    input  logic                  DONE,
    output logic [(1<<EBW)-1:0]   GNT,
    output logic [EBW-1:0]        GNT_IDX,
    output logic                  GNT_VALID,
    output logic                  TIMEOUT
);
    localparam int N = 1 << EBW;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     gnt_reg, gnt_next;
    logic [EBW-1:0]   idx_reg, idx_next;
    logic [EBW-1:0]   last_reg, last_next;
    logic [HBW-1:0]   hold_reg, hold_next;
    logic             timeout_reg, timeout_next;

    // Rotate the request vector so bit 0 is the requester just after LAST.
    logic [2*N-1:0]   req_dbl;
    logic [EBW-1:0]   start_idx;
    logic [N-1:0]     req_rot;
    logic [EBW-1:0]   offset;
    logic [EBW-1:0]   win_idx;
    logic [N-1:0]     win_onehot;

    assign req_dbl   = {REQ, REQ};
    assign start_idx = last_reg + EBW'(1);
    assign req_rot   = N'(req_dbl >> start_idx);

    always_comb begin
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = EBW'(k);
            end
        end
    end

    assign win_idx = start_idx + offset;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == EBW'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        idx_next     = idx_reg;
        last_next    = last_reg;
        hold_next    = hold_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|REQ) begin
                    gnt_next   = win_onehot;
                    idx_next   = win_idx;
                    last_next  = win_idx;
                    hold_next  = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (DONE || !REQ[idx_reg]) begin
                    gnt_next   = '0;
                    state_next = IDLE;
                end else if (hold_reg == HBW'(MAX_HOLD - 1)) begin
                    gnt_next     = '0;
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    hold_next = hold_reg + HBW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            idx_reg     <= '0;
            last_reg    <= EBW'(N - 1);
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            idx_reg     <= idx_next;
            last_reg    <= last_next;
            hold_reg    <= hold_next;
            timeout_reg <= timeout_next;
        end
    end

    assign GNT       = gnt_reg;
    assign GNT_IDX   = idx_reg;
    assign GNT_VALID = (state_reg == BUSY);
    assign TIMEOUT   = timeout_reg;

endmodule
